interrupt_request_gen: RTL and testbench
========================================

// Module: interrupt_request_gen
// PURPOSE
//  Requester side of the CPU interrupt interface. Collects peripheral events
//  (video/timer/keyboard) into masked, sticky status bits. Drives IRQ_L as a level
//  and NMI_L as a timed low pulse. The CPU edge-captures NMI_L and level-samples IRQ_L.
//  Sits on the system bus as a small memory-mapped register block.
// PARAMETERS
//  IRQ_W            8  number of IRQ sources / IRQEN,IRQST width
//  NMI_PULSE_CYCLES 4  fclk cycles NMI_L held low per NMI (>=2)
//  NMI_GAP_CYCLES   4  min fclk cycles NMI_L held high between pulses (>=1)
// PORTS
//  fclk     in   1      system clock; all logic on posedge
//  RES_L    in   1      reset, asynchronous, active-low
//  irq_src  in   IRQ_W  IRQ event inputs, fclk-synchronous, rising edge = event
//  nmi_src  in   3      NMI events [0]=DLI [1]=VBI [2]=RESET key, rising edge = event
//  cs       in   1      register select
//  we       in   1      1=write, 0=read (qualified by cs)
//  addr     in   3      register address
//  wdata    in   8      write data
//  rdata    out  8      read data, registered
//  IRQ_L    out  1      active-low level interrupt request to CPU
//  NMI_L    out  1      active-low NMI pulse to CPU
// BEHAVIOUR
//  Reset (RES_L=0, async): IRQEN=0, IRQST=0, NMIEN=0, NMIST=0, edge regs=0,
//   rdata=0, IRQ_L=1, NMI_L=1, NMI FSM=IDLE, counters=0, queue flag=0.
//  Edge detect: prev regs sample sources each cycle; event = src & ~prev.
//   A source held high yields exactly one event.
//  Register map (bits above IRQ_W / 3 read 0):
//   0 IRQEN  R/W  enable mask
//   1 IRQST  R    sticky pending; W: write-1-to-clear
//   2 NMIEN  R/W  bits[2:0] enable
//   3 NMIST  R    bits[2:0] sticky; W: any value clears all (NMIRES)
//   4 IRQFRC W    sets IRQST bits where wdata=1; reads 0
//   5-7      reads 0, writes ignored
//  Read: cs&~we at cycle N -> rdata valid at N+1 and held until the next read.
//  IRQST[i] set on event regardless of IRQEN[i]. Set has priority over a
//   same-cycle W1C or FRC clear of that bit.
//  IRQ_L registered: IRQ_L <= ~|(IRQST & IRQEN). One-cycle latency after event
//   or clear. Enabling a bit that is already pending asserts IRQ_L next cycle.
//  NMIST[k] set on nmi_src[k] event. Set wins over a same-cycle NMIRES write.
//  nmi_fire = |(nmi_event & NMIEN). Disabled NMI events still set NMIST.
//  NMI FSM:
//   IDLE: if nmi_fire or queued -> ASSERT, NMI_L=0, cnt=NMI_PULSE_CYCLES-1,
//    clear queued.
//   ASSERT: NMI_L=0. At cnt==0 -> GAP, NMI_L=1, cnt=NMI_GAP_CYCLES-1.
//    Otherwise decrement cnt.
//   GAP: NMI_L=1. At cnt==0 -> IDLE. Otherwise decrement cnt.
//   First low cycle of NMI_L is the cycle after the event.
//   nmi_fire while in ASSERT/GAP: see CONFIGURATION. Never extends the current
//    pulse or shortens the gap.
//  Writing NMIEN=0 mid-pulse does not abort the pulse. It does clear the
//   queued flag.
// CONFIGURATION
//  INTGEN_NMI_QUEUE_EN defined: one-deep queue. nmi_fire during ASSERT/GAP sets
//   queued. IDLE with queued starts a new pulse in the same cycle it enters IDLE.
//   Further fires while queued merge into that single queued pulse.
//  Not defined: nmi_fire during ASSERT/GAP is dropped; NMIST still records it.
// TESTING
//  T1 reset: RES_L=0 mid-pulse -> NMI_L=1, IRQ_L=1, regs 0, immediately (async).
//  T2 IRQ: IRQEN=8'h04, irq_src[2] rises -> IRQ_L=0 next cycle, IRQST=8'h04.
//   Write IRQST 8'h04 -> IRQ_L=1 next cycle.
//  T3 mask: irq_src[5] rises with IRQEN=0 -> IRQ_L=1, IRQST=8'h20.
//   Then IRQEN=8'h20 -> IRQ_L=0 next cycle.
//  T4 NMI: NMIEN=3'b010, nmi_src[1] held high 10 cycles -> exactly one NMI_L
//   low of 4 cycles, NMIST=3'b010. NMIRES write -> NMIST=0.
//  T5 back-to-back: VBI event, then DLI event 2 cycles later.
//   QUEUE_EN: two pulses, 4-cycle gap between them.
//   Without: one pulse; NMIST=3'b011 either way.
//  T6 collision: W1C of IRQST[1] in same cycle as irq_src[1] event -> bit stays 1.
//   IRQFRC 8'h80 with IRQEN[7]=1 -> IRQ_L=0.

Source files
------------

// File: rtl/interrupt_request_gen.sv
// Interrupt requester: sticky masked IRQ status driving IRQ_L, plus a timed NMI_L pulse generator.
// Define INTGEN_NMI_QUEUE_EN to hold one NMI that arrives while a pulse or gap is in progress.
module interrupt_request_gen #(
    parameter int IRQ_W            = 8,
    parameter int NMI_PULSE_CYCLES = 4,
    parameter int NMI_GAP_CYCLES   = 4
) (
    input  logic             fclk,
    input  logic             RES_L,
    input  logic [IRQ_W-1:0] irq_src,
    input  logic [2:0]       nmi_src,
    input  logic             cs,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata,
    output logic             IRQ_L,
    output logic             NMI_L
);

    localparam int CNT_MAX = (NMI_PULSE_CYCLES > NMI_GAP_CYCLES) ? NMI_PULSE_CYCLES : NMI_GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(NMI_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(NMI_GAP_CYCLES - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ASSERT = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    logic [IRQ_W-1:0] irq_prev, irqen, irqst;
    logic [IRQ_W-1:0] irq_event, irq_w1c, irq_frc;
    logic [2:0]       nmi_prev, nmien, nmist, nmi_event;
    logic             wr, rd, nmi_res, nmi_fire;
    logic             start_req, gap_req;
    logic [7:0]       rd_val;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;

    assign wr        = cs & we;
    assign rd        = cs & ~we;
    assign irq_event = irq_src & ~irq_prev;
    assign nmi_event = nmi_src & ~nmi_prev;
    assign irq_w1c   = (wr && addr == 3'd1) ? wdata[IRQ_W-1:0] : '0;
    assign irq_frc   = (wr && addr == 3'd4) ? wdata[IRQ_W-1:0] : '0;
    assign nmi_res   = wr && addr == 3'd3;
    assign nmi_fire  = |(nmi_event & nmien);

`ifdef INTGEN_NMI_QUEUE_EN
    logic queued, q_keep, nmien_clr;

    // Writing NMIEN=0 discards a waiting NMI; a fire in the same cycle still queues.
    assign nmien_clr = wr && addr == 3'd2 && wdata[2:0] == 3'd0;
    assign q_keep    = queued & ~nmien_clr;
    assign start_req = nmi_fire | q_keep;
    assign gap_req   = nmi_fire | q_keep;

    always_ff @(posedge fclk or negedge RES_L) begin
        if (!RES_L)
            queued <= 1'b0;
        else if (state == ST_IDLE || (state == ST_GAP && cnt == '0))
            queued <= 1'b0;
        else
            queued <= q_keep | nmi_fire;
    end
`else
    assign start_req = nmi_fire;
    assign gap_req   = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        case (addr)
            3'd0:    rd_val = 8'(irqen);
            3'd1:    rd_val = 8'(irqst);
            3'd2:    rd_val = {5'b0, nmien};
            3'd3:    rd_val = {5'b0, nmist};
            default: rd_val = '0;
        endcase
    end

    // Event sets always override a same-cycle clear of the same bit.
    always_ff @(posedge fclk or negedge RES_L) begin
        if (!RES_L) begin
            irq_prev <= '0;
            nmi_prev <= '0;
            irqen    <= '0;
            irqst    <= '0;
            nmien    <= '0;
            nmist    <= '0;
            rdata    <= '0;
            IRQ_L    <= 1'b1;
        end else begin
            irq_prev <= irq_src;
            nmi_prev <= nmi_src;
            irqst    <= (irqst & ~irq_w1c) | irq_frc | irq_event;
            nmist    <= (nmi_res ? 3'b000 : nmist) | nmi_event;
            IRQ_L    <= ~|(irqst & irqen);
            if (wr && addr == 3'd0)
                irqen <= wdata[IRQ_W-1:0];
            if (wr && addr == 3'd2)
                nmien <= wdata[2:0];
            if (rd)
                rdata <= rd_val;
        end
    end

    always_ff @(posedge fclk or negedge RES_L) begin
        if (!RES_L) begin
            state <= ST_IDLE;
            cnt   <= '0;
            NMI_L <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state <= ST_ASSERT;
                        NMI_L <= 1'b0;
                        cnt   <= PULSE_LD;
                    end
                end
                ST_ASSERT: begin
                    if (cnt == '0) begin
                        state <= ST_GAP;
                        NMI_L <= 1'b1;
                        cnt   <= GAP_LD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (gap_req) begin
                        // Back-to-back pulse: the gap is exactly NMI_GAP_CYCLES long.
                        state <= ST_ASSERT;
                        NMI_L <= 1'b0;
                        cnt   <= PULSE_LD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    NMI_L <= 1'b1;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_request_gen.sv
// Self-checking bench for interrupt_request_gen: directed vector table, NMI pulse sequences,
// async reset, then randomized traffic against a timeline-based reference model.
module tb_interrupt_request_gen;

    localparam int P = 4;
    localparam int G = 4;

    logic       fclk = 1'b0;
    logic       RES_L = 1'b0;
    logic [7:0] irq_src = '0;
    logic [2:0] nmi_src = '0;
    logic       cs = 1'b0, we = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       IRQ_L, NMI_L;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: register contents plus the NMI pulse timeline.
    logic [7:0] m_irq_prev, m_irqen, m_irqst, m_rdata;
    logic [2:0] m_nmi_prev, m_nmien, m_nmist;
    logic       m_irq_l, m_q;
    int         cyc = 0;
    int         m_s;

    typedef struct {
        logic       cs;
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] irq;
        logic [2:0] nmi;
        logic       irq_l;
        logic       nmi_l;
        logic [7:0] rd;
    } vec_t;

    vec_t tv[$];

    interrupt_request_gen #(.IRQ_W(8), .NMI_PULSE_CYCLES(P), .NMI_GAP_CYCLES(G)) dut (
        .fclk(fclk), .RES_L(RES_L), .irq_src(irq_src), .nmi_src(nmi_src),
        .cs(cs), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .IRQ_L(IRQ_L), .NMI_L(NMI_L)
    );

    initial forever #5 fclk = ~fclk;

    task automatic modelReset();
        m_irq_prev = '0; m_irqen = '0; m_irqst = '0; m_rdata = '0;
        m_nmi_prev = '0; m_nmien = '0; m_nmist = '0;
        m_irq_l = 1'b1; m_q = 1'b0; m_s = -1000;
    endtask

    function automatic logic modelNmiL();
        return !(cyc >= m_s && cyc < m_s + P);
    endfunction

    task automatic modelStep();
        logic [7:0] ev, w1c, frc;
        logic [2:0] nev;
        logic       fire, wr, rd, clr;
        int         busy_end;
        cyc++;
        wr = cs & we;
        rd = cs & ~we;
        m_irq_l = ~|(m_irqst & m_irqen);
        if (rd) begin
            case (addr)
                3'd0: m_rdata = m_irqen;
                3'd1: m_rdata = m_irqst;
                3'd2: m_rdata = {5'b0, m_nmien};
                3'd3: m_rdata = {5'b0, m_nmist};
                default: m_rdata = 8'h00;
            endcase
        end
        ev = irq_src & ~m_irq_prev;
        m_irq_prev = irq_src;
        nev = nmi_src & ~m_nmi_prev;
        m_nmi_prev = nmi_src;
        fire = |(nev & m_nmien);
        w1c = (wr && addr == 3'd1) ? wdata : 8'h00;
        frc = (wr && addr == 3'd4) ? wdata : 8'h00;
        m_irqst = (m_irqst & ~w1c) | frc | ev;
        m_nmist = ((wr && addr == 3'd3) ? 3'b000 : m_nmist) | nev;
        clr = wr && addr == 3'd2 && wdata[2:0] == 3'd0;
        if (wr && addr == 3'd0) m_irqen = wdata;
        if (wr && addr == 3'd2) m_nmien = wdata[2:0];
        // A pulse started at edge s is low for P samples, then high for at least G.
        busy_end = m_s + P + G;
`ifdef INTGEN_NMI_QUEUE_EN
        if (clr) m_q = 1'b0;
        if (fire) begin
            if (cyc > busy_end) m_s = cyc;
            else m_q = 1'b1;
        end
        if (m_q && cyc == busy_end) begin
            m_s = cyc;
            m_q = 1'b0;
        end
`else
        if (clr) m_q = 1'b0;
        if (fire && cyc > busy_end) m_s = cyc;
`endif
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic [2:0] a,
                                 input logic [7:0] d, input logic [7:0] irq, input logic [2:0] nmi);
        cs = c; we = w; addr = a; wdata = d; irq_src = irq; nmi_src = nmi;
        @(posedge fclk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic addRow(input logic c, input logic w, input logic [2:0] a, input logic [7:0] d,
                          input logic [7:0] irq, input logic [2:0] nmi,
                          input logic il, input logic nl, input logic [7:0] r);
        vec_t v;
        v.cs = c; v.we = w; v.addr = a; v.wdata = d; v.irq = irq; v.nmi = nmi;
        v.irq_l = il; v.nmi_l = nl; v.rd = r;
        tv.push_back(v);
    endtask

    initial begin
        logic exp_low;
        logic [7:0] irq_r;
        logic [2:0] nmi_r;

        // IRQ enable, W1C, masking, set-vs-clear collision and IRQFRC.
        addRow(1,1,3'd0,8'h04,8'h00,3'd0, 1,1,8'h00);
        addRow(0,0,3'd0,8'h00,8'h04,3'd0, 1,1,8'h00);
        addRow(1,0,3'd1,8'h00,8'h04,3'd0, 0,1,8'h04);
        addRow(1,1,3'd1,8'h04,8'h04,3'd0, 0,1,8'h04);
        addRow(0,0,3'd0,8'h00,8'h00,3'd0, 1,1,8'h04);
        addRow(0,0,3'd0,8'h00,8'h20,3'd0, 1,1,8'h04);
        addRow(1,0,3'd1,8'h00,8'h20,3'd0, 1,1,8'h20);
        addRow(1,1,3'd0,8'h20,8'h20,3'd0, 1,1,8'h20);
        addRow(0,0,3'd0,8'h00,8'h20,3'd0, 0,1,8'h20);
        addRow(1,1,3'd1,8'h20,8'h20,3'd0, 0,1,8'h20);
        addRow(0,0,3'd0,8'h00,8'h00,3'd0, 1,1,8'h20);
        addRow(1,1,3'd0,8'h82,8'h00,3'd0, 1,1,8'h20);
        addRow(1,1,3'd1,8'h02,8'h02,3'd0, 1,1,8'h20);
        addRow(1,0,3'd1,8'h00,8'h02,3'd0, 0,1,8'h02);
        addRow(1,1,3'd1,8'h02,8'h02,3'd0, 0,1,8'h02);
        addRow(0,0,3'd0,8'h00,8'h00,3'd0, 1,1,8'h02);
        addRow(1,1,3'd4,8'h80,8'h00,3'd0, 1,1,8'h02);
        addRow(1,0,3'd4,8'h00,8'h00,3'd0, 0,1,8'h00);
        addRow(1,0,3'd1,8'h00,8'h00,3'd0, 0,1,8'h80);
        addRow(1,1,3'd1,8'h80,8'h00,3'd0, 0,1,8'h80);
        addRow(1,0,3'd0,8'h00,8'h00,3'd0, 1,1,8'h82);
        addRow(1,0,3'd6,8'h00,8'h00,3'd0, 1,1,8'h00);

        modelReset();
        repeat (2) @(posedge fclk);
        #1;
        checkOutput("reset IRQ_L", {7'b0, IRQ_L}, 8'h01);
        checkOutput("reset NMI_L", {7'b0, NMI_L}, 8'h01);
        checkOutput("reset rdata", rdata, 8'h00);
        @(negedge fclk);
        RES_L = 1'b1;
        @(posedge fclk);
        #1;

        foreach (tv[i]) begin
            applyStimulus(tv[i].cs, tv[i].we, tv[i].addr, tv[i].wdata, tv[i].irq, tv[i].nmi);
            checkOutput($sformatf("row%0d IRQ_L", i), {7'b0, IRQ_L}, {7'b0, tv[i].irq_l});
            checkOutput($sformatf("row%0d NMI_L", i), {7'b0, NMI_L}, {7'b0, tv[i].nmi_l});
            checkOutput($sformatf("row%0d rdata", i), rdata, tv[i].rd);
        end

        // VBI held high for 10 cycles yields exactly one 4-cycle pulse.
        applyStimulus(1, 1, 3'd2, 8'h02, 8'h00, 3'd0);
        checkOutput("nmien wr NMI_L", {7'b0, NMI_L}, 8'h01);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 3'b010);
            checkOutput($sformatf("held vbi k%0d NMI_L", k), {7'b0, NMI_L}, (k < P) ? 8'h00 : 8'h01);
        end
        applyStimulus(1, 0, 3'd3, 8'h00, 8'h00, 3'd0);
        checkOutput("nmist after vbi", rdata, 8'h02);
        applyStimulus(1, 1, 3'd3, 8'h00, 8'h00, 3'd0);
        applyStimulus(1, 0, 3'd3, 8'h00, 8'h00, 3'd0);
        checkOutput("nmist after nmires", rdata, 8'h00);

        // VBI then DLI two cycles later.
        applyStimulus(1, 1, 3'd2, 8'h03, 8'h00, 3'd0);
        for (int k = 0; k < 16; k++) begin
            nmi_r = (k == 0) ? 3'b010 : (k == 2) ? 3'b001 : 3'b000;
            applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, nmi_r);
`ifdef INTGEN_NMI_QUEUE_EN
            exp_low = (k < P) || (k >= P + G && k < 2 * P + G);
`else
            exp_low = (k < P);
`endif
            checkOutput($sformatf("b2b k%0d NMI_L", k), {7'b0, NMI_L}, {7'b0, ~exp_low});
        end
        applyStimulus(1, 0, 3'd3, 8'h00, 8'h00, 3'd0);
        checkOutput("nmist b2b", rdata, 8'h03);

        // Asynchronous reset in the middle of an NMI pulse with IRQ_L asserted.
        applyStimulus(1, 1, 3'd0, 8'h01, 8'h00, 3'd0);
        applyStimulus(1, 1, 3'd4, 8'h01, 8'h00, 3'd0);
        applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 3'b001);
        applyStimulus(0, 0, 3'd0, 8'h00, 8'h00, 3'b000);
        checkOutput("pre-reset NMI_L", {7'b0, NMI_L}, 8'h00);
        checkOutput("pre-reset IRQ_L", {7'b0, IRQ_L}, 8'h00);
        #2 RES_L = 1'b0;
        #1;
        checkOutput("async reset NMI_L", {7'b0, NMI_L}, 8'h01);
        checkOutput("async reset IRQ_L", {7'b0, IRQ_L}, 8'h01);
        checkOutput("async reset rdata", rdata, 8'h00);
        modelReset();
        @(negedge fclk);
        RES_L = 1'b1;
        @(posedge fclk);
        #1;
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1, 0, 3'(a), 8'h00, 8'h00, 3'd0);
            checkOutput($sformatf("post-reset reg%0d", a), rdata, 8'h00);
        end

        // Randomized traffic against the reference model.
        irq_r = '0;
        nmi_r = '0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) irq_r = irq_r ^ 8'($urandom);
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, 7) == 0) nmi_r[b] = ~nmi_r[b];
            applyStimulus($urandom_range(0, 2) == 0, 1'($urandom), 3'($urandom_range(0, 7)),
                          8'($urandom), irq_r, nmi_r);
            checkOutput("rand IRQ_L", {7'b0, IRQ_L}, {7'b0, m_irq_l});
            checkOutput("rand NMI_L", {7'b0, NMI_L}, {7'b0, modelNmiL()});
            checkOutput("rand rdata", rdata, m_rdata);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
